kernel_cc_fifo_rr_merge: RTL
============================

Name: kernel_cc_fifo_rr_merge

Overview:
Round-robin scheduler that merges NUM_IN first-word-fall-through FIFO read sides into one FIFO write side. It sits between the per-PE kernel_cc FIFOs (w64, shift-register style) and a shared downstream consumer FIFO. Each grant is a burst of up to BURST_LEN beats, bounding the latency any one requester can impose on the others. Every merged beat carries its source index.

Parameters:
NUM_IN, 4, number of upstream FIFOs (2..8)
DATA_WIDTH, 64, beat width
IDX_WIDTH, 2, width of source index, ceil(log2(NUM_IN)), min 1
BURST_LEN, 4, max beats per grant (1..255)
CNT_WIDTH, 8, width of burst beat counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
sched_en  in  1  1 = arbitration allowed; 0 = no new grants, current grant ends at next beat boundary
in_empty_n  in  NUM_IN  per-input FIFO not-empty (bit i = input i)
in_read  out  NUM_IN  per-input FIFO read strobe, one-hot or zero
in_dout  in  NUM_IN*DATA_WIDTH  per-input FIFO head data, input i at bits [i*DW +: DW]
out_full_n  in  1  downstream FIFO not-full
out_write  out  1  downstream write strobe
out_din  out  DATA_WIDTH  downstream write data
out_src  out  IDX_WIDTH  source index of current beat
busy  out  1  1 while in GRANT state

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Ports named clk and reset.
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0. Outputs: in_read=0, out_write=0, busy=0, out_src=0, out_din=in_dout[0 slice].
- Two states: IDLE, GRANT.
- IDLE, if sched_en=1 and any in_empty_n bit is set:
  - Select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_IN.
  - grant_idx<=sel, beat_cnt<=0, go to GRANT.
  - No transfer occurs in IDLE.
- Beat (combinational, GRANT only): xfer = in_empty_n[grant_idx] & out_full_n.
  - in_read[grant_idx] = xfer; all other in_read bits = 0.
  - out_write = xfer.
  - out_din = in_dout slice at grant_idx; out_src = grant_idx (both also driven when xfer=0).
- GRANT, on xfer: beat_cnt<=beat_cnt+1.
- GRANT exits to IDLE with rr_ptr<=(grant_idx+1) mod NUM_IN when any of:
  - xfer and beat_cnt==BURST_LEN-1 (burst done; that beat is still written);
  - in_empty_n[grant_idx]=0 (source ran dry; no beat that cycle);
  - sched_en=0 and no xfer that cycle. If xfer and sched_en=0, the beat completes, then exit.
- out_full_n=0 with source non-empty: hold GRANT, no beat, beat_cnt unchanged (backpressure never ends a burst).
- Latency: a request seen in IDLE at cycle t gives its first beat at cycle t+1 at the earliest. One IDLE bubble cycle between consecutive grants, including re-grant of the same input.
- Fairness: with all inputs continuously non-empty, grants go 0,1,2,...,NUM_IN-1,0,... with BURST_LEN beats each.
- Non-power-of-two NUM_IN: index arithmetic wraps explicitly at NUM_IN; unused index codes are never granted.
- Reset mid-burst: state returns to IDLE the next edge, and no read/write strobe is asserted in the reset cycle. The upstream FIFO is not rewound; beats already read are considered delivered.
- in_dout is sampled only when in_empty_n of that input is 1. The block must not assert in_read to an empty input or out_write to a full output.

Optional Feature:
KERNEL_CC_RR_STATS_EN
- Defined: adds output stat_beats (NUM_IN*32) with one counter per input. A counter increments on each xfer from its input, saturates at 32'hFFFFFFFF, and clears on reset.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package kernel_cc_sched_pkg holds: state enum (IDLE, GRANT), the rr-select function (first set bit from pointer, modulo NUM_IN), and the stat width constant (32).
- One sub-module, kernel_cc_rr_pick: purely combinational, takes req vector and rr_ptr, outputs sel and any_req. Reused by future arbiters.

Test Plan:
- All 4 inputs always non-empty, out_full_n=1, BURST_LEN=4 -> out_src sequence 0,0,0,0,(bubble),1,1,1,1,(bubble),2,... data order preserved per input.
- Only input 2 non-empty with 2 words, rr_ptr=0 -> grant 2, two beats, exit on empty, rr_ptr=3, busy falls next cycle.
- Input 1 granted, out_full_n=0 for 5 cycles mid-burst after beat 2 -> no in_read/out_write for those cycles; beats 3,4 follow once full_n=1; exactly 4 beats total.
- sched_en dropped on the same cycle as beat 1 of a grant -> beat 1 written, then IDLE; no new grant while sched_en=0.
- Reset asserted during beat 2 of a burst from input 3 -> in_read=0, out_write=0 in the reset cycle; after reset, rr_ptr=0 and next grant starts scanning at input 0.
- With KERNEL_CC_RR_STATS_EN, 10 beats from input 0 and 3 from input 3 -> stat_beats[0]=10, [3]=3, others 0.

Source files
------------

// File: rtl/kernel_cc_sched_pkg.sv
// Shared definitions for the kernel_cc FIFO merge schedulers:
// the FSM state encoding, the statistics counter width and the
// round-robin "first set bit from pointer" selection helper.
package kernel_cc_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  // Width of each per-input beat counter (optional statistics).
  localparam int STAT_WIDTH = 32;

  // Widest request vector the helper understands.
  localparam int RR_MAX_IN = 8;

  // Returns the first set bit of req scanning ptr, ptr+1, ... with the index
  // wrapping explicitly at num_in, so unused index codes are never chosen.
  // Returns 0 when no bit is set; callers qualify the result with |req.
  function automatic logic [2:0] rr_first(input logic [RR_MAX_IN-1:0] req,
                                          input logic [2:0]           ptr,
                                          input int                   num_in);
    logic [2:0] sel;
    logic       found;
    int         idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_IN; i++) begin
      idx = int'(ptr) + i;
      if (idx >= num_in) idx = idx - num_in;
      if ((i < num_in) && !found && (idx >= 0) && (idx < num_in)) begin
        if (req[idx[2:0]]) begin
          sel   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/kernel_cc_rr_pick.sv
// Purely combinational round-robin picker: given a request vector and the
// round-robin pointer, reports the first requester at or after the pointer
// (wrapping at NUM_IN) and whether any request is present.
module kernel_cc_rr_pick
  import kernel_cc_sched_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_IN-1:0]    req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] sel,
  output logic                 any_req
);

  logic [RR_MAX_IN-1:0] req_pad;
  logic [2:0]           ptr_pad;
  logic [2:0]           sel_pad;

  // Widen to the helper's fixed width, pick, and narrow back.
  always_comb begin
    req_pad = RR_MAX_IN'(req);
    ptr_pad = 3'(rr_ptr);
    sel_pad = rr_first(req_pad, ptr_pad, NUM_IN);
    sel     = IDX_WIDTH'(sel_pad);
    any_req = |req;
  end

endmodule

// File: rtl/kernel_cc_fifo_rr_merge.sv
// Round-robin merge of NUM_IN first-word-fall-through FIFO read sides into
// one FIFO write side. Each grant is a burst of up to BURST_LEN beats; every
// merged beat carries its source index on out_src.
//
// Handshake: a beat moves in a cycle exactly when the granted input shows
// in_empty_n=1 and the downstream shows out_full_n=1; in that cycle in_read
// (one-hot, granted bit) and out_write are both high and out_din/out_src
// hold the beat. Neither strobe is ever raised toward an empty input or a
// full output, nor during reset.
//
// Optional build macro: KERNEL_CC_RR_STATS_EN adds stat_beats, one
// saturating 32-bit beat counter per input.
module kernel_cc_fifo_rr_merge
  import kernel_cc_sched_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 2,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sched_en,
  input  logic [NUM_IN-1:0]            in_empty_n,
  output logic [NUM_IN-1:0]            in_read,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [DATA_WIDTH-1:0]        out_din,
  output logic [IDX_WIDTH-1:0]         out_src,
  output logic                         busy,
`ifdef KERNEL_CC_RR_STATS_EN
  output logic [NUM_IN*STAT_WIDTH-1:0] stat_beats,
`endif
  output logic                         dbg_state
);

  sched_state_e          state;
  sched_state_e          state_nxt;
  logic [IDX_WIDTH-1:0]  rr_ptr;
  logic [IDX_WIDTH-1:0]  grant_idx;
  logic [IDX_WIDTH-1:0]  grant_inc;
  logic [IDX_WIDTH-1:0]  pick_sel;
  logic                  pick_any;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  src_ne;
  logic                  xfer;
  logic                  burst_last;
  logic                  grant_exit;

  kernel_cc_rr_pick #(
    .NUM_IN    (NUM_IN),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req     (in_empty_n),
    .rr_ptr  (rr_ptr),
    .sel     (pick_sel),
    .any_req (pick_any)
  );

  // Beat qualification and grant-exit conditions for the current grant.
  always_comb begin
    src_ne     = in_empty_n[grant_idx];
    xfer       = (state == GRANT) && src_ne && out_full_n && !reset;
    burst_last = (beat_cnt == CNT_WIDTH'(BURST_LEN - 1));
    // Backpressure alone never ends a burst; a dry source, a dropped
    // sched_en or the last beat of the burst does.
    grant_exit = !src_ne || !sched_en || (xfer && burst_last);
    grant_inc  = (grant_idx == IDX_WIDTH'(NUM_IN - 1)) ? '0
                                                       : grant_idx + IDX_WIDTH'(1);
  end

  // State register plus grant bookkeeping (pointer, granted input, beat count).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == GRANT) begin
            grant_idx <= pick_sel;
            beat_cnt  <= '0;
          end
        end
        GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          if (grant_exit) rr_ptr <= grant_inc;
        end
        default: ;
      endcase
    end
  end

  // Next-state: grant from IDLE when allowed and requested, leave GRANT on exit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sched_en && pick_any) state_nxt = GRANT;
      GRANT:   if (grant_exit)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: strobes only on a qualified beat; data and index always follow the grant.
  always_comb begin
    in_read   = '0;
    out_write = xfer;
    if (xfer) in_read[grant_idx] = 1'b1;
    if (reset) begin
      out_din = in_dout[0 +: DATA_WIDTH];
      out_src = '0;
    end else begin
      out_din = in_dout[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      out_src = grant_idx;
    end
    busy      = (state == GRANT);
    dbg_state = state;
  end

`ifdef KERNEL_CC_RR_STATS_EN
  logic [STAT_WIDTH-1:0] stat_cnt [NUM_IN];

  // Per-input saturating beat counters, cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (reset) begin
        stat_cnt[i] <= '0;
      end else if (in_read[i] && (stat_cnt[i] != '1)) begin
        stat_cnt[i] <= stat_cnt[i] + STAT_WIDTH'(1);
      end
    end
  end

  // Flatten the counters onto the statistics port.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      stat_beats[i*STAT_WIDTH +: STAT_WIDTH] = stat_cnt[i];
    end
  end
`endif

endmodule
